// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner for the MIPS execute stage: iterative 32-bit MULT/MULTU/DIV/DIVU
// (33 cycles per op) plus direct MTHI/MTLO writes.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        is_div_r;
    logic        is_signed_r;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;
    logic [31:0] a_raw;
    logic [31:0] opnd;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;

    logic        load;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_ge;
    logic        neg_res;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    // A new op may start from IDLE or in the FIX cycle, giving 33-cycle throughput.
    always_comb begin
        load      = start && ((state == IDLE) || (state == FIX));
        a_mag     = (!op[0] && a[31]) ? (~a + 32'd1) : a;
        b_mag     = (!op[0] && b[31]) ? (~b + 32'd1) : b;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_trial = div_shift - {1'b0, opnd};
        div_ge    = div_shift[32] | ~div_trial[32];
    end

    // Sign correction; the 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
    always_comb begin
        neg_res  = is_signed_r & (sign_a ^ sign_b);
        prod_fix = neg_res ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
        quot_fix = neg_res ? (~acc_lo + 32'd1) : acc_lo;
        rem_fix  = (is_signed_r & sign_a) ? (~acc_hi + 32'd1) : acc_hi;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (is_div_r) begin
            if (b_zero) begin
                fix_hi = a_raw;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            is_div_r    <= 1'b0;
            is_signed_r <= 1'b0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            a_raw       <= 32'd0;
            opnd        <= 32'd0;
            acc_hi      <= 32'd0;
            acc_lo      <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;

            if (load) begin
                state       <= CALC;
                busy        <= 1'b1;
                cnt         <= 5'd0;
                is_div_r    <= op[1];
                is_signed_r <= ~op[0];
                sign_a      <= ~op[0] & a[31];
                sign_b      <= ~op[0] & b[31];
                b_zero      <= (b == 32'd0);
                a_raw       <= a;
                acc_hi      <= 32'd0;
                opnd        <= op[1] ? b_mag : a_mag;
                acc_lo      <= op[1] ? a_mag : b_mag;
            end

            case (state)
                IDLE: begin
                    if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (is_div_r) begin
                        acc_hi <= div_ge ? div_trial[31:0] : div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    hi          <= fix_hi;
                    lo          <= fix_lo;
                    done        <= 1'b1;
                    div_by_zero <= is_div_r & b_zero;
                    if (!start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
